// File: rtl/or_unit_scheduler.sv
// Round-robin scheduler sharing one registered bitwise-OR unit among NUM_REQ requesters.
// Each operation takes a GRANT cycle and a RESULT cycle; RESULT also arbitrates the next winner.
module or_unit_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] a_in,
   input  logic [NUM_REQ*DATA_W-1:0] b_in,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         y_out,
   output logic                      y_valid,
   output logic [ID_W-1:0]           y_id,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RESULT = 2'd2
   } state_t;

   // Returns {found, index} of the first set request after 'last', wrapping modulo NUM_REQ.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [ID_W-1:0]    last);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (r[idx]) begin
            res = {1'b1, ID_W'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_t               state_q;
   logic [ID_W-1:0]      last_q;
   logic [ID_W-1:0]      win_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [DATA_W-1:0]    y_out_q;
   logic                 y_valid_q;
   logic [ID_W-1:0]      y_id_q;
   logic                 busy_q;

   logic [ID_W:0]        pick_d;
   logic                 win_ok_d;
   logic [ID_W-1:0]      win_d;
   logic [DATA_W-1:0]    a_d;
   logic [DATA_W-1:0]    b_d;

   // Arbitration result and operand slices of the current winner.
   always_comb begin
      pick_d   = rr_pick(req, last_q);
      win_ok_d = pick_d[ID_W];
      win_d    = pick_d[ID_W-1:0];
      a_d      = a_in[int'(win_q)*DATA_W +: DATA_W];
      b_d      = b_in[int'(win_q)*DATA_W +: DATA_W];
   end

   // Scheduler FSM with registered outputs; y_out_q holds the captured operands' OR.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= ID_W'(NUM_REQ - 1);
         win_q     <= '0;
         gnt_q     <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
         y_id_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, RESULT: begin
               y_valid_q <= 1'b0;
               if (win_ok_d) begin
                  win_q   <= win_d;
                  last_q  <= win_d;
                  gnt_q   <= onehot(win_d);
                  state_q <= GRANT;
                  busy_q  <= 1'b1;
               end else begin
                  gnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            GRANT: begin
               gnt_q     <= '0;
               y_out_q   <= a_d | b_d;
               y_id_q    <= win_q;
               y_valid_q <= 1'b1;
               state_q   <= RESULT;
               busy_q    <= 1'b1;
            end
            default: begin
               state_q   <= IDLE;
               gnt_q     <= '0;
               y_valid_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign y_out   = y_out_q;
   assign y_valid = y_valid_q;
   assign y_id    = y_id_q;
   assign busy    = busy_q;

endmodule

// File: doc/or_unit_scheduler.md
Name: or_unit_scheduler

Overview:
- Round-robin scheduler that shares one registered bitwise-OR evaluation unit among NUM_REQ requesters.
- Arbitrates requests, grants one requester at a time and captures that requester's operands.
- Returns the registered result tagged with the requester index.
- Sits between the training-lab stimulus sources and the shared OR datapath.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- DATA_W, 8: operand and result width in bits.
- ID_W, $clog2(NUM_REQ): width of the requester index.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  NUM_REQ  per-requester request level; bit i belongs to requester i.
- a_in  input  NUM_REQ*DATA_W  packed A operands; requester i occupies bits [i*DATA_W +: DATA_W].
- b_in  input  NUM_REQ*DATA_W  packed B operands, same packing as a_in.
- gnt  output  NUM_REQ  one-hot grant, high for exactly one cycle per operation.
- y_out  output  DATA_W  result, A | B of the granted requester.
- y_valid  output  1  one-cycle pulse; y_out and y_id are valid.
- y_id  output  ID_W  index of the requester that owns y_out.
- busy  output  1  high in GRANT and RESULT states.

Behaviour:
- Clock and reset
  - One clock.
  - Reset is synchronous and active-low: rst_n low at a rising edge of clk resets everything.
- Reset values
  - Outputs: gnt=0, y_out=0, y_valid=0, y_id=0, busy=0.
  - State=IDLE.
  - Round-robin pointer last_id=NUM_REQ-1, so requester 0 has first priority.
  - Operand registers cleared.
- FSM states: IDLE, GRANT, RESULT.
- IDLE
  - If req==0: stay in IDLE.
  - Otherwise choose the winner as the first set req bit searching upward from last_id+1, wrapping modulo NUM_REQ.
  - Register the winner index, set last_id=winner, go to GRANT.
- GRANT (one cycle)
  - gnt = one-hot(winner).
  - Capture a_in and b_in slices of the winner at the end of this cycle.
  - Go to RESULT.
- RESULT (one cycle)
  - y_out = captured A | captured B, computed bit by bit at full DATA_W with no width change.
  - y_valid=1, y_id=winner.
  - In the same cycle, arbitrate req exactly as in IDLE (pointer already advanced).
  - Any req set: go to GRANT with the new winner. Else: go to IDLE.
- Latency
  - req first sampled high in IDLE at edge N: gnt high in cycle N+1, y_valid high in cycle N+2.
  - Sustained contention: one operation every 2 cycles.
- Output timing
  - gnt and y_valid are registered outputs, each exactly one cycle wide.
  - y_out and y_id hold their last value after y_valid drops.
- Requester rules
  - Hold req and operands stable until its gnt cycle has completed.
  - Dropping req during its own GRANT cycle does not cancel the operation; the result is still delivered.
  - Requester drops req in the cycle after gnt, or keeps it high to queue another operation. Re-arbitration is fair: every other active requester is served first.
- Boundary conditions
  - Wrap-around: last_id=NUM_REQ-1 searches from 0. If the only requester is last_id itself, it is granted again (no idle bubble beyond the FSM cycles).
  - Simultaneous requests resolve in a single cycle; no starvation. Worst-case wait is (NUM_REQ-1)*2 cycles after the current operation.
  - Reset mid-operation (GRANT or RESULT): the in-flight operation is discarded, no y_valid is produced, and the pointer returns to NUM_REQ-1.
  - Request bits that change while busy are sampled only in the RESULT cycle.
- Behaviour is fully deterministic: no X propagation from unselected operand slices.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with req=4'b1111 → gnt=0, y_valid=0, busy=0, y_out=0 throughout; first grant after release goes to requester 0.
- Single request: req=4'b0010, a slice1=8'h0F, b slice1=8'hF0, starting from IDLE at edge N → gnt=4'b0010 in cycle N+1; y_valid=1, y_out=8'hFF, y_id=1 in cycle N+2; return to IDLE.
- OR truth table: requester 2 with a=8'h0C, b=8'h0A → y_out=8'h0E. Also a=8'h00, b=8'h00 → y_out=8'h00.
- Contention: req=4'b1111 held for 10 cycles → grants in order 0,1,2,3,0 on cycles N+1, N+3, N+5, N+7, N+9, each followed by y_valid with the matching y_id.
- Wrap and repeat: after a grant to 3, hold only req=4'b1000 → requester 3 granted again 2 cycles later. Then req=4'b1001 → requester 0 is granted before 3.
- Reset mid-operation: assert rst_n=0 during the GRANT cycle → no y_valid pulse is ever seen for that operation; after release, req=4'b0100 is granted with y_id=2 and the correct result.
